// File: rtl/slfifo_pkg.sv
// Shared types and constants for the slave-FIFO transmit byte source.
package slfifo_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic MODE_PATTERN = 1'b0;
  localparam logic MODE_EXT     = 1'b1;

endpackage

// File: rtl/slfifo_byte_fifo.sv
// Small synchronous byte FIFO; head entry is presented directly, no fall-through.
module slfifo_byte_fifo
  import slfifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (rd_en && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/slfifo_tx_source.sv
// Packetised byte source (test pattern or external stream) feeding the FX3 write engine.
module slfifo_tx_source
  import slfifo_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PKT_LEN = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   mode,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(PKT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PKT_LEN - 1);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  logic              active;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;

  slfifo_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (m_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign m_valid = !empty;
  assign m_last  = !empty && (rd_cnt_q == CNT_MAX);
  assign busy    = (state_q != ST_IDLE) || !empty;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;

    active  = (state_q != ST_IDLE);
    wr_en   = active && !full && ((mode_q == MODE_PATTERN) || s_valid);
    s_ready = active && (mode_q == MODE_EXT) && !full;
    wr_data = (mode_q == MODE_EXT) ? s_data : pat_q;
    rd_en   = !empty && m_ready;

    if (wr_en) begin
      wr_cnt_d = (wr_cnt_q == CNT_MAX) ? '0 : wr_cnt_q + CNT_W'(1);
      if (mode_q == MODE_PATTERN) begin
        pat_d = pat_q + DATA_W'(1);
      end
    end
    if (rd_en) begin
      rd_cnt_d = (rd_cnt_q == CNT_MAX) ? '0 : rd_cnt_q + CNT_W'(1);
    end

    // Leaving RUN looks at the post-write count so a packet is never left partial.
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          mode_d  = mode;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = (wr_cnt_d == '0) ? ST_IDLE : ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (wr_en && (wr_cnt_q == CNT_MAX)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_PATTERN;
      pat_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_slfifo_tx_source.sv
// Self-checking bench for slfifo_tx_source: packet-level reference model and output scoreboard.
module tb_slfifo_tx_source;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned PKT_A = 8;
  localparam int unsigned PKT_W = 300;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable, mode, s_valid, m_ready;
  logic [7:0]       s_data;
  logic             s_ready, m_valid, m_last, busy;
  logic [7:0]       m_data;
  logic [LVL_W-1:0] level;

  logic             enable_w, m_ready_w;
  logic             s_ready_w, m_valid_w, m_last_w, busy_w;
  logic [7:0]       m_data_w;
  logic [LVL_W-1:0] level_w;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_pat = 8'h00;

  logic [7:0] qa_d[$];
  bit         qa_l[$];
  logic [7:0] qw_d[$];
  bit         qw_l[$];

  slfifo_tx_source #(.DEPTH(DEPTH), .PKT_LEN(PKT_A)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .level(level), .busy(busy)
  );

  slfifo_tx_source #(.DEPTH(DEPTH), .PKT_LEN(PKT_W)) dut_w (
    .clk(clk), .reset_n(reset_n), .enable(enable_w), .mode(1'b0),
    .s_data(8'h00), .s_valid(1'b0), .s_ready(s_ready_w),
    .m_data(m_data_w), .m_valid(m_valid_w), .m_ready(m_ready_w), .m_last(m_last_w),
    .level(level_w), .busy(busy_w)
  );

  always #5 clk = ~clk;

  // Record every transfer mid-cycle; it completes on the following rising edge.
  always @(negedge clk) begin
    if (reset_n && m_valid && m_ready) begin
      qa_d.push_back(m_data);
      qa_l.push_back(m_last);
    end
    if (reset_n && m_valid_w && m_ready_w) begin
      qw_d.push_back(m_data_w);
      qw_l.push_back(m_last_w);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; mode = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    m_ready = 1'b0; enable_w = 1'b0; m_ready_w = 1'b0;
    step(); step();
    n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got=%b exp=0", m_valid); else n_pass++;
    n_chk++; if (m_last !== 1'b0) $display("FAIL reset_m_last got=%b exp=0", m_last); else n_pass++;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got=%b exp=0", s_ready); else n_pass++;
    n_chk++; if (level !== 5'd0) $display("FAIL reset_level got=%0d exp=0", level); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_chk++; if (m_data !== 8'h00) $display("FAIL reset_m_data got=%h exp=00", m_data); else n_pass++;
    n_chk++; if (m_valid_w !== 1'b0) $display("FAIL reset_w_m_valid got=%b exp=0", m_valid_w); else n_pass++;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_pattern();
    bit done = 0;
    qa_d.delete(); qa_l.delete();
    m_ready = 1'b1; mode = 1'b0; enable = 1'b1;
    step();
    enable = 1'b0;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL pat_latency_early got=%b exp=0", m_valid); else n_pass++;
    step();
    n_chk++; if (m_valid !== 1'b1) $display("FAIL pat_latency_valid got=%b exp=1", m_valid); else n_pass++;
    n_chk++; if (m_data !== exp_pat) $display("FAIL pat_first_byte got=%h exp=%h", m_data, exp_pat); else n_pass++;
    for (int c = 0; c < 60; c++) begin
      step();
      if (qa_d.size() >= PKT_A) begin done = 1; break; end
    end
    n_chk++; if (!done) $display("FAIL pat_timeout got=%0d bytes exp=%0d", qa_d.size(), PKT_A); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL pat_busy_after_last got=%b exp=0", busy); else n_pass++;
    for (int c = 0; c < 20; c++) step();
    n_chk++; if (qa_d.size() != PKT_A) $display("FAIL pat_count got=%0d exp=%0d", qa_d.size(), PKT_A); else n_pass++;
    for (int i = 0; i < qa_d.size() && i < int'(PKT_A); i++) begin
      logic [7:0] e = exp_pat + 8'(i);
      n_chk++; if (qa_d[i] !== e) $display("FAIL pat_byte[%0d] got=%h exp=%h", i, qa_d[i], e); else n_pass++;
      n_chk++; if (qa_l[i] !== (i == int'(PKT_A) - 1)) $display("FAIL pat_last[%0d] got=%b exp=%b", i, qa_l[i], i == int'(PKT_A) - 1); else n_pass++;
    end
    exp_pat = exp_pat + 8'(PKT_A);
  endtask

  task automatic test_backpressure();
    bit done = 0;
    qa_d.delete(); qa_l.delete();
    m_ready = 1'b0; mode = 1'b0; enable = 1'b1;
    for (int c = 0; c < 30; c++) step();
    n_chk++; if (level !== 5'd16) $display("FAIL bp_level_full got=%0d exp=16", level); else n_pass++;
    n_chk++; if (m_data !== exp_pat) $display("FAIL bp_head got=%h exp=%h", m_data, exp_pat); else n_pass++;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL bp_s_ready got=%b exp=0", s_ready); else n_pass++;
    for (int c = 0; c < 5; c++) step();
    n_chk++; if (level !== 5'd16) $display("FAIL bp_level_hold got=%0d exp=16", level); else n_pass++;
    n_chk++; if (m_last !== 1'b0) $display("FAIL bp_head_last got=%b exp=0", m_last); else n_pass++;
    for (int c = 0; c < 60; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    enable = 1'b0;
    for (int c = 0; c < 600; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
      if (!busy) begin done = 1; break; end
    end
    m_ready = 1'b1;
    n_chk++; if (!done) $display("FAIL bp_drain_timeout got=busy exp=idle"); else n_pass++;
    n_chk++; if ((qa_d.size() % PKT_A) != 0 || qa_d.size() < 16)
      $display("FAIL bp_count got=%0d exp=multiple of %0d and >=16", qa_d.size(), PKT_A); else n_pass++;
    for (int i = 0; i < qa_d.size(); i++) begin
      logic [7:0] e = exp_pat + 8'(i);
      bit el = ((i % int'(PKT_A)) == int'(PKT_A) - 1);
      n_chk++; if (qa_d[i] !== e || qa_l[i] !== el)
        $display("FAIL bp_byte[%0d] got=%h/%b exp=%h/%b", i, qa_d[i], qa_l[i], e, el); else n_pass++;
    end
    exp_pat = exp_pat + 8'(qa_d.size());
  endtask

  task automatic test_disable_mid();
    bit done = 0;
    qa_d.delete(); qa_l.delete();
    m_ready = 1'b1; mode = 1'b0; enable = 1'b1;
    step();                  // state is RUN after this edge
    step(); step(); step();  // three writes
    enable = 1'b0;
    step();
    n_chk++; if (busy !== 1'b1) $display("FAIL dis_busy_finish got=%b exp=1", busy); else n_pass++;
    for (int c = 0; c < 100; c++) begin
      step();
      if (!busy) begin done = 1; break; end
    end
    n_chk++; if (!done) $display("FAIL dis_timeout got=busy exp=idle"); else n_pass++;
    n_chk++; if (qa_d.size() != PKT_A) $display("FAIL dis_count got=%0d exp=%0d", qa_d.size(), PKT_A); else n_pass++;
    for (int i = 0; i < qa_d.size(); i++) begin
      logic [7:0] e = exp_pat + 8'(i);
      bit el = (i == int'(PKT_A) - 1);
      n_chk++; if (qa_d[i] !== e || qa_l[i] !== el)
        $display("FAIL dis_byte[%0d] got=%h/%b exp=%h/%b", i, qa_d[i], qa_l[i], e, el); else n_pass++;
    end
    exp_pat = exp_pat + 8'(qa_d.size());
  endtask

  task automatic test_external();
    logic [7:0] acc[$];
    int  nidx = 1;
    bit  take;
    bit  saw_full = 0;
    bit  done = 0;
    qa_d.delete(); qa_l.delete();
    m_ready = 1'b0; mode = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
    step();
    n_chk++; if (s_ready !== 1'b0) $display("FAIL ext_idle_s_ready got=%b exp=0", s_ready); else n_pass++;
    enable = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (level == 5'd16) begin
        saw_full = 1;
        n_chk++; if (s_ready !== 1'b0) $display("FAIL ext_full_s_ready got=%b exp=0", s_ready); else n_pass++;
      end
      take = s_valid && s_ready;
      @(posedge clk); #1;
      if (take) begin
        acc.push_back(s_data);
        s_data = (nidx == 1) ? 8'h5A : 8'($urandom);
        nidx++;
      end
      if (cyc == 20) mode = 1'b0;
      if (cyc == 150) enable = 1'b0;
      m_ready = (cyc < 40) ? 1'b0 : 1'($urandom_range(0, 1));
      s_valid = (cyc < 40) ? ((cyc % 5) != 0) : 1'($urandom_range(0, 1));
      if (cyc > 150 && !busy) begin done = 1; break; end
    end
    s_valid = 1'b0; m_ready = 1'b1;
    n_chk++; if (!done) $display("FAIL ext_timeout got=busy exp=idle"); else n_pass++;
    n_chk++; if (!saw_full) $display("FAIL ext_never_full got=0 exp=1"); else n_pass++;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL ext_idle_end_s_ready got=%b exp=0", s_ready); else n_pass++;
    n_chk++; if (qa_d.size() != acc.size() || (acc.size() % PKT_A) != 0 || acc.size() < 2)
      $display("FAIL ext_count got=%0d exp=%0d (multiple of %0d)", qa_d.size(), acc.size(), PKT_A); else n_pass++;
    for (int i = 0; i < qa_d.size() && i < acc.size(); i++) begin
      bit el = ((i % int'(PKT_A)) == int'(PKT_A) - 1);
      n_chk++; if (qa_d[i] !== acc[i] || qa_l[i] !== el)
        $display("FAIL ext_byte[%0d] got=%h/%b exp=%h/%b", i, qa_d[i], qa_l[i], acc[i], el); else n_pass++;
    end
    mode = 1'b0;
  endtask

  task automatic test_pattern_wrap();
    bit done = 0;
    qw_d.delete(); qw_l.delete();
    m_ready_w = 1'b1; enable_w = 1'b1;
    step();
    enable_w = 1'b0;
    for (int c = 0; c < 800; c++) begin
      step();
      if (!busy_w && qw_d.size() > 0) begin done = 1; break; end
    end
    n_chk++; if (!done) $display("FAIL wrap_timeout got=busy exp=idle"); else n_pass++;
    n_chk++; if (qw_d.size() != PKT_W) $display("FAIL wrap_count got=%0d exp=%0d", qw_d.size(), PKT_W); else n_pass++;
    for (int i = 0; i < qw_d.size(); i++) begin
      logic [7:0] e = 8'(i);
      bit el = (i == int'(PKT_W) - 1);
      n_chk++; if (qw_d[i] !== e || qw_l[i] !== el)
        $display("FAIL wrap_byte[%0d] got=%h/%b exp=%h/%b", i, qw_d[i], qw_l[i], e, el); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    bit done = 0;
    qa_d.delete(); qa_l.delete();
    m_ready = 1'b0; mode = 1'b0; enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (level == 5'd10) begin hit = 1; break; end
    end
    n_chk++; if (!hit) $display("FAIL rst_level10_timeout got=%0d exp=10", level); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (m_valid !== 1'b0) $display("FAIL rst_mid_m_valid got=%b exp=0", m_valid); else n_pass++;
    n_chk++; if (m_last !== 1'b0) $display("FAIL rst_mid_m_last got=%b exp=0", m_last); else n_pass++;
    n_chk++; if (s_ready !== 1'b0) $display("FAIL rst_mid_s_ready got=%b exp=0", s_ready); else n_pass++;
    n_chk++; if (level !== 5'd0) $display("FAIL rst_mid_level got=%0d exp=0", level); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else n_pass++;
    n_chk++; if (m_data !== 8'h00) $display("FAIL rst_mid_m_data got=%h exp=00", m_data); else n_pass++;
    @(posedge clk); #3;
    reset_n = 1'b1;
    exp_pat = 8'h00;
    qa_d.delete(); qa_l.delete();
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (!busy) begin done = 1; break; end
    end
    n_chk++; if (!done) $display("FAIL rst_after_timeout got=busy exp=idle"); else n_pass++;
    n_chk++; if (qa_d.size() == 0 || (qa_d.size() % PKT_A) != 0)
      $display("FAIL rst_after_count got=%0d exp=nonzero multiple of %0d", qa_d.size(), PKT_A); else n_pass++;
    for (int i = 0; i < qa_d.size(); i++) begin
      logic [7:0] e = exp_pat + 8'(i);
      bit el = ((i % int'(PKT_A)) == int'(PKT_A) - 1);
      n_chk++; if (qa_d[i] !== e || qa_l[i] !== el)
        $display("FAIL rst_after_byte[%0d] got=%h/%b exp=%h/%b", i, qa_d[i], qa_l[i], e, el); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_backpressure();
    test_disable_mid();
    test_pattern_wrap();
    test_external();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/slfifo_tx_source.md
# slfifo_tx_source

Upstream byte source for the FX3 slave-FIFO write engine. Produces a byte stream, either an internal incrementing test pattern or an external byte stream, buffers it in a small synchronous FIFO, and presents it with a valid/ready handshake and a per-packet last marker. The write engine consumes it and drives `slwr`/`fdata` toward the FX3. Packets are always emitted whole: disabling mid-packet finishes the packet first.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, at least 4.
- `PKT_LEN`, 1024: bytes per packet; at least 2, at most 65535.
- `clk` in 1: single clock, shared with the write engine.
- `reset_n` in 1: reset, asynchronous, active-low.
- `enable` in 1: level; start or continue producing packets.
- `mode` in 1: 0 = internal counter pattern, 1 = external stream; sampled only in IDLE.
- `s_data` in 8: external byte (mode 1).
- `s_valid` in 1: external byte valid.
- `s_ready` out 1: external byte accepted when `s_valid && s_ready`.
- `m_data` out 8: byte to the write engine.
- `m_valid` out 1: `m_data` valid.
- `m_ready` in 1: the write engine takes the byte when `m_valid && m_ready`.
- `m_last` out 1: current `m_data` is the final byte of a packet (drives the pktend decision).
- `level` out clog2(DEPTH)+1: FIFO occupancy.
- `busy` out 1: high when the state is not IDLE or the FIFO is non-empty.

## Operation
- States:
  - IDLE: no writes. Transitions to RUN when `enable`=1; `mode` is latched on that transition.
  - RUN: produce bytes. When `enable` drops: go to IDLE if `wr_cnt`==0, otherwise go to FINISH.
  - FINISH: keep producing until the current packet's last byte is written, then go to IDLE. `enable` has no effect in FINISH.
- Write side:
  - `wr_en` = (state is RUN or FINISH) and not full and (latched mode 0, or `s_valid`).
  - `s_ready` = (state is RUN or FINISH) and latched mode 1 and not full. It is 0 in mode 0.
  - `wr_cnt` counts bytes written, 0..PKT_LEN-1, and wraps to 0 after the write at PKT_LEN-1.
- Pattern:
  - 8-bit register, starts at 0x00, increments by 1 per written byte, wraps 0xFF→0x00.
  - It keeps its value across enable cycles. Only reset clears it.
- Read side:
  - `m_valid` = FIFO non-empty; `m_data` = head entry.
  - `rd_cnt` counts transfers (`m_valid && m_ready`) and wraps at PKT_LEN.
  - `m_last` = `m_valid` and `rd_cnt`==PKT_LEN-1.
- `mode` changes outside IDLE are ignored.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `s_ready`=0, `level`=0, `busy`=0, `m_data`=0x00. State=IDLE, pattern=0x00, `wr_cnt`=`rd_cnt`=0.
- Reset asserted mid-operation takes effect immediately. FIFO contents and partial packets are discarded, with no pktend.
- Start latency:
  - `enable` rises before edge N, so the state is RUN after N.
  - The first write occurs at N+1.
  - `m_valid` is 1 in the cycle after that write edge.
- Steady state: 1 byte/cycle in, 1 byte/cycle out, no bubbles.
- Full FIFO: no write is accepted. `s_ready`=0 even if a read happens in the same cycle (`s_ready` is registered-path safe; it depends on full only).
- Empty FIFO: `m_valid`=0. A write into an empty FIFO becomes visible the next cycle; there is no fall-through in the same cycle.
- Simultaneous read and write: `level` stays unchanged.
- `busy` falls the cycle after the final byte (with `m_last`=1) is taken and the state is IDLE.

## Structure
- Package `slfifo_pkg`:
  - data width 8;
  - state enum IDLE/RUN/FINISH;
  - mode constants MODE_PATTERN=0 and MODE_EXT=1.
- Sub-module `slfifo_byte_fifo`:
  - parameter DEPTH;
  - pointers one bit wider than the address, for full/empty detection;
  - ports: `clk`, `reset_n`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `level`.
- Top level holds the FSM, the pattern register, `wr_cnt` and `rd_cnt`.

## Test plan
- Pattern mode:
  - Stimulus: DEPTH=16, PKT_LEN=8, `m_ready`=1, `enable` high for 1 cycle.
  - Required: exactly 8 bytes 0x00..0x07; `m_last` only on 0x07; then IDLE; `busy`=0.
- Backpressure:
  - Stimulus: `m_ready`=0 with `enable`=1.
  - Required: `level` reaches 16 and holds; `s_ready`/writes stop.
  - Then release `m_ready`: bytes continue in order with no loss or duplication.
- External mode:
  - Stimulus: `mode`=1; drive 0xA5, 0x5A, ... with `s_valid` gaps.
  - Required: output sequence identical; `s_ready`=0 while full and in IDLE.
- Disable mid-packet:
  - Stimulus: PKT_LEN=8, drop `enable` after 3 bytes are written.
  - Required: state FINISH, then 5 more bytes, `m_last` on the 8th, then IDLE.
- Pattern wrap:
  - Stimulus: PKT_LEN=300, run 1 packet.
  - Required: bytes 0x00..0xFF, 0x00..0x2B; `m_last` on 0x2B.
- Reset:
  - Stimulus: assert `reset_n`=0 mid-packet with `level`=10.
  - Required: all outputs go to their reset values immediately.
  - After release with `enable`=1: first byte 0x00.
